// File: rtl/aes_inv_key_step.sv
// Inverse AES-128 key-schedule step: K_r -> K_(r-1), byte-serial through one shared S-box.
// Latency is 7 edges from an accepted start to valid_o; all outputs are registered.
module aes_inv_key_step (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [3:0]   rnd_i,
  output logic [127:0] key_o,
  output logic [3:0]   rnd_o,
  output logic         valid_o,
  output logic         busy_o,
  output logic         err_o
);

  typedef enum logic [1:0] {IDLE, XOR, SUB, LOAD} state_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t          state_q;
  logic [127:0]    key_q;
  logic [3:0]      rnd_q;
  logic [31:0]     w1_q, w2_q, w3_q;
  logic [0:3][7:0] sub_q;
  logic [1:0]      cnt_q;

  logic [7:0]      sbox_in;
  logic [7:0]      sbox_out;
  logic [7:0]      rcon;
  logic [31:0]     w0_d;
  logic            rnd_legal;

  // Byte cnt of RotWord(w3); cnt 0 is the most significant byte.
  always_comb begin
    sbox_in = w3_q[23:16];
    unique case (cnt_q)
      2'd0: sbox_in = w3_q[23:16];
      2'd1: sbox_in = w3_q[15:8];
      2'd2: sbox_in = w3_q[7:0];
      2'd3: sbox_in = w3_q[31:24];
      default: sbox_in = w3_q[23:16];
    endcase
  end

  assign sbox_out = SBOX[{8'd255 - sbox_in, 3'b000} +: 8];

  always_comb begin
    rcon = 8'h00;
    case (rnd_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign w0_d      = key_q[127:96] ^ sub_q ^ {rcon, 24'h000000};
  assign rnd_legal = (rnd_i != 4'd0) && (rnd_i <= 4'd10);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      key_q   <= '0;
      rnd_q   <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      w3_q    <= '0;
      sub_q   <= '0;
      cnt_q   <= '0;
      key_o   <= '0;
      rnd_o   <= '0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if (rnd_legal) begin
              key_q   <= key_i;
              rnd_q   <= rnd_i;
              busy_o  <= 1'b1;
              state_q <= XOR;
            end else begin
              err_o   <= 1'b1;
            end
          end
        end
        XOR: begin
          w1_q    <= key_q[127:96] ^ key_q[95:64];
          w2_q    <= key_q[95:64]  ^ key_q[63:32];
          w3_q    <= key_q[63:32]  ^ key_q[31:0];
          cnt_q   <= 2'd0;
          state_q <= SUB;
        end
        SUB: begin
          sub_q[cnt_q] <= sbox_out;
          cnt_q        <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_q <= LOAD;
        end
        LOAD: begin
          key_o   <= {w0_d, w1_q, w2_q, w3_q};
          rnd_o   <= rnd_q - 4'd1;
          valid_o <= 1'b1;
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
